// File: rtl/bus_arbiter_mux.sv
// Multi-channel request arbiter with a single registered output slot.
// Picks one requesting channel per accept (fixed priority or round-robin),
// captures its data into the output register and advances the round-robin
// pointer past the winner.
module bus_arbiter_mux #(
    parameter int unsigned CHANNELS = 24,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SEL_W    = 5
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      rr_mode,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic [CHANNELS-1:0]       grant
);

    typedef enum logic [0:0] {StEmpty, StFull} stateT;

    stateT            stateQ;
    logic [SEL_W-1:0] ptrQ;
    logic [WIDTH-1:0] dataQ;
    logic [SEL_W-1:0] selQ;

    int unsigned      winIdx;
    logic [WIDTH-1:0] winData;
    logic             anyReq;
    logic             accept;

    assign anyReq = |req;
    // Slot can take a word when empty or when the held word leaves this cycle.
    assign accept = clear && anyReq && ((stateQ == StEmpty) || out_ready);

    // Winner search: first request at or above the start index, else the lowest request (wrap).
    always_comb begin
        int unsigned start;
        int unsigned hiIdx;
        int unsigned loIdx;
        logic        foundHi;
        logic        foundLo;
        start   = rr_mode ? 32'(ptrQ) : 32'd0;
        hiIdx   = 0;
        loIdx   = 0;
        foundHi = 1'b0;
        foundLo = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (req[i] && (i >= start) && !foundHi) begin
                foundHi = 1'b1;
                hiIdx   = i;
            end
            if (req[i] && !foundLo) begin
                foundLo = 1'b1;
                loIdx   = i;
            end
        end
        winIdx = foundHi ? hiIdx : loIdx;
    end

    // Data mux and one-hot acceptance strobe for the selected channel.
    always_comb begin
        winData = '0;
        grant   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (i == winIdx) begin
                winData  = data_in[i*WIDTH +: WIDTH];
                grant[i] = accept;
            end
        end
    end

    // Output slot state, captured word and round-robin pointer.
    always_ff @(posedge clock) begin
        if (!clear) begin
            stateQ <= StEmpty;
            ptrQ   <= '0;
            dataQ  <= '0;
            selQ   <= '0;
        end else if (accept) begin
            stateQ <= StFull;
            dataQ  <= winData;
            selQ   <= SEL_W'(winIdx);
            ptrQ   <= (winIdx == CHANNELS - 1) ? '0 : SEL_W'(winIdx + 1);
        end else if ((stateQ == StFull) && out_ready) begin
            // Word drained with nothing to replace it; data and index are kept.
            stateQ <= StEmpty;
        end
    end

    assign out_valid = (stateQ == StFull);
    assign out_data  = dataQ;
    assign out_sel   = selQ;

endmodule

// File: doc/bus_arbiter_mux.md
BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 Parameter CHANNELS, default 24: number of source channels; legal range 1..32.
REQ-002 Parameter WIDTH, default 32: data width of each channel and of the output.
REQ-003 Parameter SEL_W, default 5: width of out_sel; SHALL be >= 1 and >= ceil(log2(CHANNELS)).
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 clear  input  1  reset, synchronous, active-low.
REQ-006 req  input  CHANNELS  per-channel request; bit i set means channel i offers data.
REQ-007 data_in  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 rr_mode  input  1  1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
REQ-009 out_ready  input  1  downstream accepts the output word this cycle.
REQ-010 out_valid  output  1  the output register holds a word.
REQ-011 out_data  output  WIDTH  registered winning data.
REQ-012 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-013 grant  output  CHANNELS  combinational one-hot acceptance strobe; bit i high means data_in channel i is captured at this edge.

Function
REQ-014 State machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 Accept condition: accept = (|req) && (state==EMPTY || out_ready).
REQ-016 When accept=1, grant SHALL be one-hot on the winner; otherwise grant SHALL be all zero.
REQ-017 Fixed priority (rr_mode=0): the winner SHALL be the lowest-index set req bit.
REQ-018 Round-robin (rr_mode=1): the winner SHALL be the first set req bit at index >= ptr, searching upward and wrapping from CHANNELS-1 to 0.
REQ-019 ptr SHALL update to (winner+1) mod CHANNELS on every accept in either mode; ptr SHALL hold otherwise.
REQ-020 On accept, at the next edge: out_data <= winner data, out_sel <= winner index, state becomes FULL; latency from grant to out_valid is 1 cycle.
REQ-021 Back-to-back: FULL && out_ready && accept SHALL replace the word in the same edge, giving one word per cycle throughput.
REQ-022 FULL && out_ready && !(|req): state SHALL go to EMPTY; out_data and out_sel SHALL hold their last values.
REQ-023 FULL && !out_ready: out_data, out_sel, out_valid and ptr SHALL be stable; grant=0 regardless of req.
REQ-024 Deassertion of req or changes on data_in after a grant SHALL NOT affect the captured word.
REQ-025 A rr_mode change SHALL take effect on the next arbitration; ptr SHALL be retained across the change.
REQ-026 CHANNELS=1: winner is always 0; out_sel is always 0; ptr stays 0.
REQ-027 Upper bits of out_sel above ceil(log2(CHANNELS)) SHALL be zero.

Reset
REQ-028 clear=0 at a rising edge SHALL force state=EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-029 While clear=0, grant SHALL be all zero and no word SHALL be accepted.
REQ-030 Reset while FULL SHALL discard the held word with no handshake.

Verification
REQ-031 Reset with req all ones -> grant=0 and out_valid=0 during reset; first edge after release -> grant[0] pulse, then out_valid=1, out_sel=0.
REQ-032 rr_mode=0, req bits 3, 7 and 20 held, out_ready=1 -> out_sel=3 on every cycle.
REQ-033 rr_mode=1, CHANNELS=24, req bits 3, 7 and 20 held, out_ready=1 -> out_sel sequence 3, 7, 20, 3, 7 with one word per cycle; ptr wrap from 21 to 3 is covered.
REQ-034 FULL with out_sel=5 and data 32'hDEADBEEF, out_ready=0 for 4 cycles while req changes -> output stable and grant=0 throughout; out_ready=1 -> new winner appears the next cycle.
REQ-035 Single req on channel 23 for one accept, then req=0 and out_ready=1 -> out_valid falls after one cycle, out_data holds channel 23 data, and ptr wraps to 0.
REQ-036 clear=0 asserted while FULL and out_ready=0 -> next cycle out_valid=0, out_data=0, out_sel=0; a later round-robin search starts from channel 0.
